// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator: half-rate pixel enable, h/v counters, sync/blank decode.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN; otherwise frame_count reads 0.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic       pix_en_r;
   logic [9:0] h_r;
   logic [9:0] v_r;
   logic       line_start_r;
   logic       frame_start_r;
   logic       h_last_s;
   logic       v_last_s;
   logic       frame_wrap_s;
   logic       hs_s;
   logic       vs_s;
   logic       blank_n_s;

   assign h_last_s     = (h_r == H_LAST);
   assign v_last_s     = (v_r == V_LAST);
   assign frame_wrap_s = pix_en_r & h_last_s & v_last_s;

   // Pixel enable, raster counters and start-of-line/frame pulses.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_en_r      <= 1'b0;
         h_r           <= 10'd0;
         v_r           <= 10'd0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         pix_en_r      <= ~pix_en_r;
         // Pulses are set on the wrap edge itself so they line up with DrawX==0.
         line_start_r  <= pix_en_r & h_last_s;
         frame_start_r <= frame_wrap_s;
         if (pix_en_r) begin
            if (h_last_s) begin
               h_r <= 10'd0;
               if (v_last_s) begin
                  v_r <= 10'd0;
               end else begin
                  v_r <= v_r + 10'd1;
               end
            end else begin
               h_r <= h_r + 10'd1;
            end
         end
      end
   end

   // Sync and blanking decode straight from the counter registers.
   always_comb begin
      hs_s      = 1'b1;
      vs_s      = 1'b1;
      blank_n_s = 1'b0;
      if ((h_r >= H_SYNC_START) && (h_r <= H_SYNC_END)) begin
         hs_s = 1'b0;
      end else begin
         hs_s = 1'b1;
      end
      if ((v_r >= V_SYNC_START) && (v_r <= V_SYNC_END)) begin
         vs_s = 1'b0;
      end else begin
         vs_s = 1'b1;
      end
      if ((h_r < H_VIS_END) && (v_r < V_VIS_END)) begin
         blank_n_s = 1'b1;
      end else begin
         blank_n_s = 1'b0;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count_r;

   // Frame counter advances on the same edge that raises frame_start.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_count_r <= 8'd0;
      end else if (frame_wrap_s) begin
         frame_count_r <= frame_count_r + 8'd1;
      end
   end

   assign frame_count = frame_count_r;
`else
   assign frame_count = 8'h00;
`endif

   assign VGA_CLK     = pix_en_r;
   assign VGA_HS      = hs_s;
   assign VGA_VS      = vs_s;
   assign VGA_BLANK_N = blank_n_s;
   assign VGA_SYNC_N  = 1'b0;
   assign DrawX       = h_r;
   assign DrawY       = v_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line timing and reset,
// and a shrunken-raster instance (8x6 total) so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

   logic       clk;
   logic       rst_a, rst_b;
   logic       vga_clk_a, hs_a, vs_a, blank_a, sync_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic [7:0] fc_a;
   logic       vga_clk_b, hs_b, vs_b, blank_b, sync_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;
   logic [7:0] fc_b;

   int checks = 0;
   int passes = 0;

   vga_timing_gen dut (
      .Clk(clk), .Reset_n(rst_a), .VGA_CLK(vga_clk_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
      .VGA_BLANK_N(blank_a), .VGA_SYNC_N(sync_a), .DrawX(x_a), .DrawY(y_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
   );

   // Small raster: h 4 visible + 1 fp + 2 sync + 1 bp = 8; v 3 + 1 + 1 + 1 = 6.
   vga_timing_gen #(
      .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_s (
      .Clk(clk), .Reset_n(rst_b), .VGA_CLK(vga_clk_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
      .VGA_BLANK_N(blank_b), .VGA_SYNC_N(sync_b), .DrawX(x_b), .DrawY(y_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fs_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         if (fs_b) ok = 1'b1;
      end
   endtask

   initial begin
      bit   found;
      int   hs_low, blank_hi, ls_cnt, fs_cnt, first_x, last_x, vs_low, first_y, max_y;
      logic [9:0] y0;
      bit   fc_en;
      logic [31:0] fc_exp;

`ifdef VGA_FRAME_COUNT_EN
      fc_en = 1'b1;
`else
      fc_en = 1'b0;
`endif

      rst_a = 1'b0;
      rst_b = 1'b0;
      #25;
      check("rst_vga_clk", vga_clk_a, 0);
      check("rst_hs", hs_a, 1);
      check("rst_vs", vs_a, 1);
      check("rst_blank_n", blank_a, 1);
      check("sync_n", sync_a, 0);
      check("rst_drawx", x_a, 0);
      check("rst_drawy", y_a, 0);
      check("rst_line_start", ls_a, 0);
      check("rst_frame_start", fs_a, 0);
      check("rst_frame_count", fc_a, 0);

      @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Release sequence: VGA_CLK 1,0,1,0 and DrawX 0,1,1,2.
      tick(); check("rel1_clk", vga_clk_a, 1); check("rel1_x", x_a, 0); check("rel1_ls", ls_a, 0);
      tick(); check("rel2_clk", vga_clk_a, 0); check("rel2_x", x_a, 1); check("rel2_ls", ls_a, 0);
      tick(); check("rel3_clk", vga_clk_a, 1); check("rel3_x", x_a, 1);
      tick(); check("rel4_clk", vga_clk_a, 0); check("rel4_x", x_a, 2);

      // One full line measured from a line_start pulse.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         tick();
         if (ls_a) found = 1'b1;
      end
      check("line_start_seen", found, 1);
      check("ls_at_x0", x_a, 0);
      check("ls_pix_en_low", vga_clk_a, 0);
      y0 = y_a;
      hs_low = 0; blank_hi = 0; ls_cnt = 0; fs_cnt = 0; first_x = -1; last_x = -1;
      for (int n = 0; n < 1600; n++) begin
         if (!hs_a) begin
            if (hs_low == 0) first_x = int'(x_a);
            last_x = int'(x_a);
            hs_low++;
         end
         if (blank_a) blank_hi++;
         if (ls_a) ls_cnt++;
         if (fs_a) fs_cnt++;
         tick();
      end
      check("hs_low_clks", hs_low, 192);
      check("hs_first_x", first_x, 656);
      check("hs_last_x", last_x, 751);
      check("blank_hi_clks", blank_hi, 1280);
      check("ls_per_line", ls_cnt, 1);
      check("fs_in_line", fs_cnt, 0);
      check("ls_period", ls_a, 1);
      check("ls_next_x", x_a, 0);
      check("ls_next_y", y_a, 32'(y0) + 32'd1);

      // Asynchronous reset mid-line with VGA_CLK high.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         tick();
         if (x_a == 10'd300 && vga_clk_a) found = 1'b1;
      end
      check("reach_x300", found, 1);
      check("pre_rst_y", y_a, 2);
      #5;
      rst_a = 1'b0;
      #1;
      check("arst_x", x_a, 0);
      check("arst_y", y_a, 0);
      check("arst_clk", vga_clk_a, 0);
      check("arst_ls", ls_a, 0);
      tick();
      check("arst_hold_x", x_a, 0);
      @(negedge clk);
      rst_a = 1'b1;
      ls_cnt = 0; fs_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (ls_a) ls_cnt++;
         if (fs_a) fs_cnt++;
      end
      check("no_ls_at_release", ls_cnt, 0);
      check("no_fs_at_release", fs_cnt, 0);
      check("post_rel_x", x_a, 50);

      // Two frames on the small raster, starting at a frame_start pulse.
      wait_fs_b(found);
      check("fs_seen", found, 1);
      check("fs_x0", x_b, 0);
      check("fs_y0", y_b, 0);
      check("fs_with_ls", ls_b, 1);
      vs_low = 0; blank_hi = 0; ls_cnt = 0; fs_cnt = 0; first_y = -1; max_y = 0; hs_low = 0;
      for (int n = 0; n < 192; n++) begin
         if (!vs_b) begin
            if (vs_low == 0) first_y = int'(y_b);
            vs_low++;
         end
         if (!hs_b) hs_low++;
         if (blank_b) blank_hi++;
         if (ls_b) ls_cnt++;
         if (fs_b) fs_cnt++;
         if (int'(y_b) > max_y) max_y = int'(y_b);
         tick();
      end
      check("s_vs_low_clks", vs_low, 32);
      check("s_vs_first_y", first_y, 4);
      check("s_hs_low_clks", hs_low, 48);
      check("s_blank_hi", blank_hi, 48);
      check("s_ls_cnt", ls_cnt, 12);
      check("s_fs_cnt", fs_cnt, 2);
      check("s_max_y", max_y, 5);
      check("s_fs_period", fs_b, 1);

      // Frame counter across 257 frame boundaries from a fresh reset.
      #5;
      rst_b = 1'b0;
      #1;
      check("s_rst_fc", fc_b, 0);
      check("s_rst_fs", fs_b, 0);
      @(negedge clk);
      rst_b = 1'b1;
      for (int k = 1; k <= 257; k++) begin
         wait_fs_b(found);
         if (!found) begin
            check("fc_fs_timeout", found, 1);
            break;
         end
         if (k >= 255) begin
            fc_exp = fc_en ? 32'(k % 256) : 32'd0;
            check($sformatf("frame_count_k%0d", k), fc_b, fc_exp);
         end
      end
      check("main_fc_idle", fc_a, fc_en ? 32'(0) : 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 H_VISIBLE, 640: active pixels per line.
REQ-002 H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync and back porch, in pixels; line total is 800.
REQ-003 V_VISIBLE, 480: active lines per frame.
REQ-004 V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync and back porch, in lines; frame total is 525.
REQ-005 Clk  in  1  system clock, 50 MHz.
REQ-006 Reset_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-007 VGA_CLK  out  1  pixel clock, Clk/2.
REQ-008 VGA_HS  out  1  horizontal sync, active-low.
REQ-009 VGA_VS  out  1  vertical sync, active-low.
REQ-010 VGA_BLANK_N  out  1  high only inside the visible region.
REQ-011 VGA_SYNC_N  out  1  constant 0.
REQ-012 DrawX  out  10  current horizontal pixel counter.
REQ-013 DrawY  out  10  current line counter.
REQ-014 line_start  out  1  one-Clk pulse when a new line begins.
REQ-015 frame_start  out  1  one-Clk pulse when a new frame begins.
REQ-016 frame_count  out  8  frame counter (see Configuration).

Function
REQ-017 Internal register pix_en SHALL toggle every Clk; VGA_CLK SHALL equal pix_en.
REQ-018 Counters SHALL advance only on Clk edges where pix_en==1; the pixel period is 2 Clk.
REQ-019 The h counter SHALL count 0..799; at 799 it SHALL wrap to 0 and advance the v counter.
REQ-020 The v counter SHALL count 0..524; when h wraps with v==524, v SHALL wrap to 0.
REQ-021 DrawX and DrawY SHALL be the h and v registers, with zero added latency.
REQ-022 VGA_HS SHALL be 0 iff 656<=h<=751.
REQ-023 VGA_VS SHALL be 0 iff 490<=v<=491.
REQ-024 VGA_BLANK_N SHALL be 1 iff h<640 and v<480.
REQ-025 VGA_HS, VGA_VS and VGA_BLANK_N SHALL be decoded from the counter registers in the same cycle.
REQ-026 line_start SHALL be registered and high for exactly the one Clk following the edge on which h becomes 0.
REQ-027 frame_start SHALL be registered and high for exactly the one Clk following the edge on which h and v both become 0.
REQ-028 Each pulse SHALL coincide with DrawX==0 (and DrawY==0 for frame_start) while pix_en==0.
REQ-029 Counter widths SHALL be 10 bits; no counter SHALL ever hold a value at or beyond its total (h>=800 or v>=525 is unreachable).
REQ-030 Derived constants (sync start/end, totals) SHALL be computed from the parameters, not hard-coded.

Reset
REQ-031 While Reset_n==0: pix_en=0, h=0, v=0, line_start=0, frame_start=0, frame_count=0.
REQ-032 While Reset_n==0, the outputs SHALL be VGA_CLK=0, VGA_HS=1, VGA_VS=1 and VGA_BLANK_N=1 (position 0,0).
REQ-033 Reset asserted mid-frame SHALL return all state to REQ-031 values immediately, with no wait for a Clk edge.
REQ-034 After reset deassertion, the first Clk edge SHALL set pix_en=1 and the second SHALL advance h to 1.
REQ-035 No line_start or frame_start pulse SHALL be generated by reset release itself.

Configuration
REQ-036 Macro VGA_FRAME_COUNT_EN defined: frame_count SHALL increment by 1 on every frame_start and wrap from 255 to 0.
REQ-037 Macro VGA_FRAME_COUNT_EN undefined: frame_count SHALL be tied to 8'h00, no counter register SHALL be synthesized, and the port SHALL still exist.

Verification
REQ-038 Release reset, then run 4 Clk -> VGA_CLK reads 1,0,1,0 and DrawX reads 0,1,1,2 after the successive edges.
REQ-039 Run one full line -> VGA_HS low for exactly 192 Clk, starting when DrawX=656; line_start period is 1600 Clk; VGA_BLANK_N high for 1280 Clk per visible line.
REQ-040 Run two frames -> frame_start period is 840000 Clk; VGA_VS low for exactly 3200 Clk at DrawY=490..491; DrawY never exceeds 524.
REQ-041 Assert Reset_n=0 at DrawX=300, DrawY=200, asynchronously between edges -> DrawX=0, DrawY=0 and VGA_CLK=0 before the next Clk edge; no pulse is generated at release.
REQ-042 With VGA_FRAME_COUNT_EN defined, run 257 frame boundaries -> frame_count reads 255 then 0 then 1; with the macro undefined -> frame_count stays 0 throughout.
